// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - WM8731 register map, sequencer state encoding and frame builder.
package codec_pkg;

  localparam logic [6:0] REG_R0  = 7'd0;
  localparam logic [6:0] REG_R1  = 7'd1;
  localparam logic [6:0] REG_R2  = 7'd2;
  localparam logic [6:0] REG_R3  = 7'd3;
  localparam logic [6:0] REG_R4  = 7'd4;
  localparam logic [6:0] REG_R5  = 7'd5;
  localparam logic [6:0] REG_R6  = 7'd6;
  localparam logic [6:0] REG_R7  = 7'd7;
  localparam logic [6:0] REG_R8  = 7'd8;
  localparam logic [6:0] REG_R9  = 7'd9;
  localparam logic [6:0] REG_R15 = 7'd15;

  typedef logic [2:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE  = 3'd0;
  localparam cfg_state_t ST_LOAD  = 3'd1;
  localparam cfg_state_t ST_ISSUE = 3'd2;
  localparam cfg_state_t ST_WAIT  = 3'd3;
  localparam cfg_state_t ST_GAP   = 3'd4;
  localparam cfg_state_t ST_DONE  = 3'd5;
  localparam cfg_state_t ST_ERROR = 3'd6;

  function automatic logic [23:0] build_frame(input logic [7:0] dev,
                                              input logic [6:0] addr,
                                              input logic [8:0] data);
    return {dev, addr, data};
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - power-up register write table, indexed by entry number.
module codec_cfg_rom
  import codec_pkg::*;
(
  input  logic [3:0] index,
  output logic [6:0] addr,
  output logic [8:0] data
);

  // Reset first, activate last; anything past the table is a harmless R9 deactivate.
  always_comb begin
    addr = REG_R9;
    data = 9'h000;
    case (index)
      4'd0:    begin addr = REG_R15; data = 9'h000; end
      4'd1:    begin addr = REG_R6;  data = 9'h010; end
      4'd2:    begin addr = REG_R0;  data = 9'h017; end
      4'd3:    begin addr = REG_R1;  data = 9'h017; end
      4'd4:    begin addr = REG_R2;  data = 9'h079; end
      4'd5:    begin addr = REG_R3;  data = 9'h079; end
      4'd6:    begin addr = REG_R4;  data = 9'h012; end
      4'd7:    begin addr = REG_R5;  data = 9'h000; end
      4'd8:    begin addr = REG_R7;  data = 9'h002; end
      4'd9:    begin addr = REG_R8;  data = 9'h000; end
      4'd10:   begin addr = REG_R9;  data = 9'h001; end
      default: begin addr = REG_R9;  data = 9'h000; end
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - walks the codec register table over I2C with retry,
// inter-write gap and response timeout.
module codec_cfg_sequencer
  import codec_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         NUM_REGS       = 11,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 500,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        i2c_ready,
  input  logic        i2c_done,
  input  logic        i2c_ack_ok,
  output logic        i2c_req,
  output logic [23:0] i2c_frame,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
);

  localparam int TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);
  localparam logic [3:0]         INDEX_LAST   = 4'(NUM_REGS - 1);

  cfg_state_t         state;
  cfg_state_t         state_next;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry;
  logic               last_ok;
  logic [6:0]         rom_addr;
  logic [8:0]         rom_data;
  logic               resp_ok;
  logic               resp_fail;
  logic               gap_end;

  codec_cfg_rom u_rom (
    .index (cfg_index),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // A done pulse in the timeout cycle takes precedence over the timeout.
  assign resp_ok   = i2c_done && i2c_ack_ok;
  assign resp_fail = (i2c_done && !i2c_ack_ok) || (!i2c_done && (timer == TIMEOUT_LAST));
  assign gap_end   = (timer == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (cfg_start) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_ISSUE;
      ST_ISSUE: if (i2c_ready) state_next = ST_WAIT;
      ST_WAIT: begin
        if (resp_ok) begin
          state_next = ST_GAP;
        end else if (resp_fail) begin
          state_next = (retry == RETRY_LAST) ? ST_ERROR : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          if (!last_ok)                     state_next = ST_ISSUE;
          else if (cfg_index == INDEX_LAST) state_next = ST_DONE;
          else                              state_next = ST_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_busy  = 1'b1;
    cfg_done  = 1'b0;
    cfg_error = 1'b0;
    i2c_req   = (state == ST_ISSUE) && i2c_ready && !rst;
    case (state)
      ST_IDLE:  cfg_busy = 1'b0;
      ST_DONE:  begin cfg_busy = 1'b0; cfg_done  = 1'b1; end
      ST_ERROR: begin cfg_busy = 1'b0; cfg_error = 1'b1; end
      default:  ;
    endcase
  end

  // One counter serves both the response timeout and the gap; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      retry     <= '0;
      last_ok   <= 1'b0;
      cfg_index <= '0;
      i2c_frame <= '0;
    end else begin
      if (state_next != state) begin
        timer <= '0;
      end else if ((state == ST_WAIT) || (state == ST_GAP)) begin
        timer <= timer + 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (cfg_start) begin
            cfg_index <= '0;
            retry     <= '0;
          end
        end
        ST_LOAD: i2c_frame <= build_frame(DEV_ADDR, rom_addr, rom_data);
        ST_WAIT: begin
          if (resp_ok) begin
            retry   <= '0;
            last_ok <= 1'b1;
          end else if (resp_fail) begin
            retry   <= retry + 1'b1;
            last_ok <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_end && last_ok && (cfg_index != INDEX_LAST)) cfg_index <= cfg_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - self-checking bench for codec_cfg_sequencer with a
// transaction-level I2C master and table model.
module tb_codec_cfg_sequencer;

  localparam int NUM_REGS  = 11;
  localparam int MAX_RETRY = 3;
  localparam int GAP       = 50;
  localparam int TMO       = 300;
  localparam int RUN_LIMIT = 20000;
  localparam int NUM_SCEN  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        i2c_ready;
  logic        i2c_done;
  logic        i2c_ack_ok;
  logic        i2c_req;
  logic [23:0] i2c_frame;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [3:0]  cfg_index;

  int errors = 0;
  int checks = 0;

  int tbl_reg [NUM_REGS] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
  int tbl_val [NUM_REGS] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h002, 'h000, 'h001};

  typedef struct {
    int          nack_entry;
    int          nack_times;
    bit          no_done;
    int          ready_hold;
    int          exp_reqs;
    bit          exp_done;
    bit          exp_error;
    int          exp_index;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
    int          exp_end;
  } scen_t;

  codec_cfg_sequencer #(
    .DEV_ADDR       (8'h34),
    .NUM_REGS       (NUM_REGS),
    .MAX_RETRY      (MAX_RETRY),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .i2c_ready  (i2c_ready),
    .i2c_done   (i2c_done),
    .i2c_ack_ok (i2c_ack_ok),
    .i2c_req    (i2c_req),
    .i2c_frame  (i2c_frame),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .cfg_index  (cfg_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_frame(input int i);
    return 24'(('h34 * 65536) + (tbl_reg[i] * 512) + tbl_val[i]);
  endfunction

  // Iteration k: drive inputs at negedge k, sample #1 later. Model tracks entry/attempt and
  // predicts when the next request, and the final DONE/ERROR, must appear.
  task automatic run_seq(input int nack_entry, input int nack_times, input bit no_done,
                         input int ready_hold, input bit rnd, input int rst_entry,
                         output int nreqs, output logic [23:0] first_frame,
                         output logic [23:0] last_frame, output bit fin_done,
                         output bit fin_error, output int fin_index, output int end_cyc);
    int idx, attempt, resp_at, next_req, end_at, rst_at;
    bit resp_ack, resp_pulse, end_done, finished;
    idx = 0; attempt = 0; resp_at = -1; end_at = -1; rst_at = -1;
    next_req = (ready_hold > 2) ? ready_hold : 2;
    resp_ack = 1'b0; resp_pulse = 1'b0; end_done = 1'b0; finished = 1'b0;
    nreqs = 0; first_frame = '0; last_frame = '0;
    fin_done = 1'b0; fin_error = 1'b0; fin_index = -1; end_cyc = -1;
    for (int cyc = 0; cyc < RUN_LIMIT; cyc++) begin
      @(negedge clk);
      cfg_start = (cyc == 0) ||
                  (rnd && (end_at < 0 || cyc < end_at) && ($urandom_range(0, 199) == 0));
      i2c_ready  = (cyc >= ready_hold);
      rst        = (cyc == rst_at);
      i2c_done   = 1'b0;
      i2c_ack_ok = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc == resp_at && resp_pulse) begin
        i2c_done   = 1'b1;
        i2c_ack_ok = resp_ack;
      end else if (rnd && resp_at < 0 && ($urandom_range(0, 49) == 0)) begin
        i2c_done = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        check("start_busy", cfg_busy, 1);
        check("start_done_clr", cfg_done, 0);
        check("start_error_clr", cfg_error, 0);
        check("start_index", cfg_index, 0);
      end
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        check("rst_req", i2c_req, 0);
        check("rst_frame", i2c_frame, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        check("rst_index", cfg_index, 0);
        finished = 1'b1;
        break;
      end
      if (i2c_req || cyc == next_req) check("req_timing", i2c_req, (cyc == next_req));
      if (i2c_req) begin
        nreqs++;
        if (nreqs == 1) first_frame = i2c_frame;
        last_frame = i2c_frame;
        check("req_frame", i2c_frame, exp_frame(idx));
        check("req_index", cfg_index, idx);
        next_req = -1;
        if (no_done) begin
          resp_pulse = 1'b0;
          resp_ack   = 1'b0;
          resp_at    = cyc + TMO;
        end else begin
          resp_pulse = 1'b1;
          resp_at    = cyc + (rnd ? int'($urandom_range(1, 20)) : 3);
          resp_ack   = rnd ? ($urandom_range(0, 3) != 0)
                           : !(idx == nack_entry && attempt < nack_times);
        end
        if (idx == rst_entry) rst_at = cyc + 1;
      end
      if (cyc == resp_at) begin
        resp_at = -1;
        if (resp_ack) begin
          attempt = 0;
          if (idx == NUM_REGS - 1) begin
            end_at   = cyc + GAP + 1;
            end_done = 1'b1;
          end else begin
            idx++;
            next_req = cyc + GAP + 2;
          end
        end else begin
          attempt++;
          if (attempt == MAX_RETRY) begin
            end_at   = cyc + 1;
            end_done = 1'b0;
          end else begin
            next_req = cyc + GAP + 1;
          end
        end
      end
      if (cyc == end_at - 1) check("busy_before_end", cfg_busy, 1);
      if (cyc == end_at) begin
        check("end_done", cfg_done, end_done);
        check("end_error", cfg_error, !end_done);
        check("end_busy", cfg_busy, 0);
        check("end_index", cfg_index, idx);
        fin_done  = cfg_done;
        fin_error = cfg_error;
        fin_index = int'(cfg_index);
        end_cyc   = cyc;
      end
      if (end_at >= 0 && cyc == end_at + 30) begin
        finished = 1'b1;
        break;
      end
    end
    check("run_complete", finished, 1);
  endtask

  initial begin
    scen_t       scen [NUM_SCEN];
    int          nreqs, fidx, fend;
    logic [23:0] ff, lf;
    bit          fdone, ferr;

    scen[0] = '{nack_entry: -1, nack_times: 0, no_done: 0, ready_hold: 0, exp_reqs: 11,
                exp_done: 1, exp_error: 0, exp_index: 10, exp_first: 24'h341E00,
                exp_last: 24'h341201, exp_end: -1};
    scen[1] = '{nack_entry: 2, nack_times: 1, no_done: 0, ready_hold: 0, exp_reqs: 12,
                exp_done: 1, exp_error: 0, exp_index: 10, exp_first: 24'h341E00,
                exp_last: 24'h341201, exp_end: -1};
    scen[2] = '{nack_entry: 4, nack_times: 3, no_done: 0, ready_hold: 0, exp_reqs: 7,
                exp_done: 0, exp_error: 1, exp_index: 4, exp_first: 24'h341E00,
                exp_last: 24'h340479, exp_end: -1};
    scen[3] = '{nack_entry: -1, nack_times: 0, no_done: 1, ready_hold: 0, exp_reqs: 3,
                exp_done: 0, exp_error: 1, exp_index: 0, exp_first: 24'h341E00,
                exp_last: 24'h341E00, exp_end: 3 * TMO + 2 * GAP + 5};
    scen[4] = '{nack_entry: -1, nack_times: 0, no_done: 0, ready_hold: 1000, exp_reqs: 11,
                exp_done: 1, exp_error: 0, exp_index: 10, exp_first: 24'h341E00,
                exp_last: 24'h341201, exp_end: -1};

    rst = 1'b1; cfg_start = 1'b0; i2c_ready = 1'b0; i2c_done = 1'b0; i2c_ack_ok = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_req", i2c_req, 0);
    check("reset_frame", i2c_frame, 0);
    check("reset_busy", cfg_busy, 0);
    check("reset_done", cfg_done, 0);
    check("reset_error", cfg_error, 0);
    check("reset_index", cfg_index, 0);
    rst = 1'b0;

    for (int i = 0; i < NUM_SCEN; i++) begin
      run_seq(scen[i].nack_entry, scen[i].nack_times, scen[i].no_done, scen[i].ready_hold,
              1'b0, -1, nreqs, ff, lf, fdone, ferr, fidx, fend);
      check($sformatf("s%0d_reqs", i), nreqs, scen[i].exp_reqs);
      check($sformatf("s%0d_done", i), fdone, scen[i].exp_done);
      check($sformatf("s%0d_error", i), ferr, scen[i].exp_error);
      check($sformatf("s%0d_index", i), fidx, scen[i].exp_index);
      check($sformatf("s%0d_first", i), ff, scen[i].exp_first);
      check($sformatf("s%0d_last", i), lf, scen[i].exp_last);
      if (scen[i].exp_end >= 0) check($sformatf("s%0d_end_cycle", i), fend, scen[i].exp_end);
    end

    run_seq(-1, 0, 1'b0, 0, 1'b0, 5, nreqs, ff, lf, fdone, ferr, fidx, fend);
    check("rst_run_reqs", nreqs, 6);
    run_seq(-1, 0, 1'b0, 0, 1'b0, -1, nreqs, ff, lf, fdone, ferr, fidx, fend);
    check("restart_first", ff, 24'h341E00);
    check("restart_done", fdone, 1);
    check("restart_reqs", nreqs, 11);

    for (int r = 0; r < 15; r++) begin
      run_seq(-1, 0, 1'b0, 0, 1'b1, -1, nreqs, ff, lf, fdone, ferr, fidx, fend);
      check("rnd_outcome", (fdone ^ ferr), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
